// File: rtl/booth_divider.sv
// booth_divider: sequential radix-2 signed divider (restoring algorithm).
// Divides operand magnitudes with one shift/subtract step per clock, then
// applies sign correction. The quotient truncates toward zero and the
// remainder takes the sign of the dividend.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             request a division (sampled only in IDLE)
//   Dividend, Divisor N-bit signed operands, latched on an accepted start
//   Quotient          N-bit signed quotient   (valid from done onward)
//   Remainder         N-bit signed remainder  (valid from done onward)
//   busy              high from the cycle after start through the done cycle
//   done              one-cycle result-valid pulse
//   div_by_zero       set when the divisor was zero
//   overflow          set for -2^(N-1) / -1
//   Count_N           remaining iterations (debug)
module booth_divider #(
  parameter int N = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [N-1:0]             Dividend,
  input  logic [N-1:0]             Divisor,
  output logic [N-1:0]             Quotient,
  output logic [N-1:0]             Remainder,
  output logic                     busy,
  output logic                     done,
  output logic                     div_by_zero,
  output logic                     overflow,
  output logic [$clog2(N+1)-1:0]   Count_N
);

  localparam int CW = $clog2(N+1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_FIX, S_DONE} state_t;

  state_t         r_state;
  logic [N-1:0]   r_dividend;
  logic [N-1:0]   r_divisor;
  logic [N-1:0]   r_mag_d;
  logic [N:0]     r_p;
  logic [N-1:0]   r_q;
  logic           r_q_neg;
  logic           r_r_neg;
  logic           r_dbz;

  logic [N-1:0]   w_mag_a;
  logic [N-1:0]   w_mag_b;
  logic [N+1:0]   w_p_sh;
  logic [N+1:0]   w_diff;
  logic           w_ovf;

  // The magnitude of -2^(N-1) wraps to 2^(N-1), which is correct unsigned.
  assign w_mag_a = r_dividend[N-1] ? -r_dividend : r_dividend;
  assign w_mag_b = r_divisor[N-1]  ? -r_divisor  : r_divisor;

  // Shift {P,Q} left by one; one extra top bit keeps the trial
  // subtraction's sign visible in w_diff[N+1].
  assign w_p_sh = {r_p, r_q[N-1]};
  assign w_diff = w_p_sh - {2'b00, r_mag_d};

  assign w_ovf = (r_dividend == {1'b1, {(N-1){1'b0}}}) && (r_divisor == '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_mag_d     <= '0;
      r_p         <= '0;
      r_q         <= '0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_dbz       <= 1'b0;
      Quotient    <= '0;
      Remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      Count_N     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dividend <= Dividend;
            r_divisor  <= Divisor;
            busy       <= 1'b1;
            r_state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_mag_d <= w_mag_b;
          r_q     <= w_mag_a;
          r_p     <= '0;
          r_q_neg <= r_dividend[N-1] ^ r_divisor[N-1];
          r_r_neg <= r_dividend[N-1];
          r_dbz   <= (r_divisor == '0);
          Count_N <= CW'(N);
          r_state <= (r_divisor == '0) ? S_FIX : S_RUN;
        end
        S_RUN: begin
          if (!w_diff[N+1]) begin
            r_p <= w_diff[N:0];
            r_q <= {r_q[N-2:0], 1'b1};
          end else begin
            r_p <= w_p_sh[N:0];
            r_q <= {r_q[N-2:0], 1'b0};
          end
          Count_N <= Count_N - 1'b1;
          if (Count_N == CW'(1)) r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_dbz) begin
            Quotient    <= '1;
            Remainder   <= r_dividend;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else if (w_ovf) begin
            Quotient    <= {1'b1, {(N-1){1'b0}}};
            Remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b1;
          end else begin
            Quotient    <= r_q_neg ? -r_q : r_q;
            Remainder   <= r_r_neg ? -r_p[N-1:0] : r_p[N-1:0];
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
          done    <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/booth_divider.md
Name: booth_divider

Overview:
- Sequential radix-2 signed divider. It is the inverse datapath of the team's Booth multiplier: it divides instead of multiplies.
- Takes two's-complement Dividend and Divisor of N bits each and performs one restoring shift/subtract step per clock on operand magnitudes.
- Applies sign correction at the end and returns a truncated quotient and a remainder whose sign follows the dividend.
- Sits beside the multiplier in the ALU datapath and uses the same start/done handshake style.

Parameters:
- N, 4, operand width in bits (N >= 2). Quotient and remainder are N bits each.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a division; sampled only in IDLE
- Dividend  input  N  signed dividend; sampled on accepted start
- Divisor  input  N  signed divisor; sampled on accepted start
- Quotient  output  N  signed quotient; valid from the done cycle onward
- Remainder  output  N  signed remainder; valid from the done cycle onward
- busy  output  1  high from the cycle after an accepted start through the done cycle
- done  output  1  one-cycle pulse when results are valid
- div_by_zero  output  1  error flag; meaning below
- overflow  output  1  error flag; meaning below
- Count_N  output  $clog2(N+1)  remaining iterations, for debug

Behaviour:
- Reset: rst is synchronous and active-high. rst=1 at a clock edge has priority over everything.
  - State goes to IDLE; all outputs go to 0, including Count_N.
  - Reset mid-operation abandons the division. No done pulse is produced for it.
- States: IDLE, LOAD, RUN, FIX, DONE.
- IDLE: start=1 latches Dividend/Divisor and goes to LOAD. start=0 stays in IDLE. Quotient/Remainder/flags hold their last values.
- LOAD (1 cycle):
  - Compute unsigned magnitudes. |-2^(N-1)| = 2^(N-1) fits in N unsigned bits.
  - Record quotient sign = sign(Dividend) XOR sign(Divisor), and remainder sign = sign(Dividend).
  - Clear the partial remainder P (N+1 bits). Load Q_reg with |Dividend|. Set Count_N = N.
  - If Divisor == 0, go to FIX with the div_by_zero path selected. Otherwise go to RUN.
- RUN (exactly N cycles); each cycle:
  - Shift {P,Q_reg} left by 1.
  - T = P - {1'b0,|Divisor|}.
  - If T >= 0: P <= T and Q_reg[0] <= 1. Otherwise P is unchanged and Q_reg[0] <= 0.
  - Count_N decrements. Leave RUN when Count_N reaches 0, going to FIX.
- FIX (1 cycle):
  - Normal path: Quotient <= quotient sign ? -Q_reg : Q_reg; Remainder <= remainder sign ? -P[N-1:0] : P[N-1:0].
  - Div-by-zero path: Quotient <= all ones; Remainder <= Dividend; div_by_zero <= 1.
  - Overflow path: Dividend == -2^(N-1) and Divisor == -1. Quotient <= -2^(N-1) (wrapped); Remainder <= 0; overflow <= 1.
  - Flags are otherwise cleared here.
- DONE (1 cycle): done=1, busy=1, then return to IDLE.
- Latency from the start cycle to done:
  - normal: N+3 edges (LOAD + N RUN + FIX + DONE);
  - divide by zero: 3 edges.
- start while busy (any state other than IDLE) is ignored; the in-flight operands are unaffected.
- start=1 in the same cycle that DONE returns to IDLE: that start is not sampled. A new start is accepted in the next IDLE cycle.
- Arithmetic rules: truncation toward zero. Identity Dividend = Quotient*Divisor + Remainder holds modulo 2^N, with |Remainder| < |Divisor| for all non-error cases.

Test Plan:
- N=4, Dividend=7, Divisor=2, start 1 cycle -> busy next cycle; done at edge 7 after start; Quotient=0011, Remainder=0001, flags 0.
- Dividend=-7 (1001), Divisor=2 -> Quotient=1101 (-3), Remainder=1111 (-1). Dividend=7, Divisor=-2 -> Quotient=1101, Remainder=0001.
- Dividend=-8 (1000), Divisor=-1 (1111) -> Quotient=1000, Remainder=0000, overflow=1. Dividend=-8, Divisor=2 -> Quotient=1100 (-4), Remainder=0, overflow=0.
- Dividend=5, Divisor=0 -> done at edge 3 after start; Quotient=1111, Remainder=0101, div_by_zero=1. A following 6/3 -> Quotient=0010, flags 0.
- Start 7/2, then pulse start with 1/1 while in RUN -> result still 3 r1; exactly one done pulse.
- Start 7/2, assert rst for 1 cycle in the 3rd RUN cycle -> all outputs 0 next edge; no done; a new start 6/-3 -> Quotient=1110, Remainder=0.
- Exhaustive N=4 sweep over all 256 operand pairs -> matches the reference model, including the error flags.
